// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, coordinate type and region helpers.
// Imported by the timing generator and by the sprite modules.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int total(input int visible, input int front,
                               input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL = total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL = total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  typedef enum logic [1:0] {
    REGION_ACTIVE,
    REGION_FRONT,
    REGION_SYNC,
    REGION_BACK
  } region_t;

  // Classifies a counter value; the same helper serves both axes.
  function automatic region_t region_of(input coord_t pos, input int visible,
                                        input int front, input int sync);
    int p;
    p = int'(pos);
    if (p < visible)                     return REGION_ACTIVE;
    else if (p < visible + front)        return REGION_FRONT;
    else if (p < visible + front + sync) return REGION_SYNC;
    else                                 return REGION_BACK;
  endfunction

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing outputs of vga_timing_gen as seen by the sprite/palette pipeline.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t DrawX;
  coord_t DrawY;
  logic   blank;
  logic   hs;
  logic   vs;
  logic   frame_start;
  logic   line_start;
  logic   hs_d;
  logic   vs_d;
  logic   blank_d;

  modport master (
    output DrawX, DrawY, blank, hs, vs, frame_start, line_start,
           hs_d, vs_d, blank_d
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, frame_start, line_start,
          hs_d, vs_d, blank_d
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register; every stage loads RESET_VALUE during reset.
// DEPTH = 0 collapses to a plain wire.
module vga_sync_delay #(
  parameter int               WIDTH       = 3,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with registered sync/blank/strobe outputs plus a
// delayed copy of the sync/blank group for the sprite ROM/palette pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int PIPE_DELAY = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int     LINE_TOTAL  = total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int     FRAME_TOTAL = total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam coord_t X_LAST      = coord_t'(LINE_TOTAL - 1);
  localparam coord_t Y_LAST      = coord_t'(FRAME_TOTAL - 1);

  coord_t  draw_x, draw_y;
  coord_t  next_x, next_y;
  region_t next_h_region, next_v_region;
  sync_t   sync_r, sync_dly;
  logic    frame_start_r, line_start_r;

  always_comb begin
    next_x = draw_x + 10'd1;
    next_y = draw_y;
    if (draw_x == X_LAST) begin
      next_x = '0;
      next_y = (draw_y == Y_LAST) ? '0 : draw_y + 10'd1;
    end
    next_h_region = region_of(next_x, H_VISIBLE, H_FRONT, H_SYNC);
    next_v_region = region_of(next_y, V_VISIBLE, V_FRONT, V_SYNC);
  end

  // Outputs are decoded from the next counts so they line up with DrawX/DrawY.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      draw_x        <= '0;
      draw_y        <= '0;
      sync_r        <= SYNC_IDLE;
      frame_start_r <= 1'b0;
      line_start_r  <= 1'b0;
    end else begin
      draw_x        <= next_x;
      draw_y        <= next_y;
      sync_r.hs     <= (next_h_region != REGION_SYNC);
      sync_r.vs     <= (next_v_region != REGION_SYNC);
      sync_r.blank  <= (next_h_region == REGION_ACTIVE) &&
                       (next_v_region == REGION_ACTIVE);
      frame_start_r <= (next_x == '0) && (next_y == '0);
      line_start_r  <= (next_x == '0);
    end
  end

  vga_sync_delay #(
    .WIDTH       ($bits(sync_t)),
    .DEPTH       (PIPE_DELAY),
    .RESET_VALUE (SYNC_IDLE)
  ) u_sync_delay (
    .clk     (vga_clk),
    .reset_n (reset_n),
    .din     (sync_r),
    .dout    (sync_dly)
  );

  assign vga.DrawX       = draw_x;
  assign vga.DrawY       = draw_y;
  assign vga.blank       = sync_r.blank;
  assign vga.hs          = sync_r.hs;
  assign vga.vs          = sync_r.vs;
  assign vga.frame_start = frame_start_r;
  assign vga.line_start  = line_start_r;
  assign vga.hs_d        = sync_dly.hs;
  assign vga.vs_d        = sync_dly.vs;
  assign vga.blank_d     = sync_dly.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing with PIPE_DELAY 2 and 0, plus a
// reduced 14x7 raster that is cheap enough to run over many whole frames.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       ls;
  } obs_t;

  typedef struct {
    int   k;
    int   x;
    int   y;
    logic blank;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
    logic blank_d;
    logic hs_d;
  } vec_t;

  logic vga_clk;
  logic rst_main_n;
  logic rst_small_n;
  int   tests_run;
  int   failures;

  vga_timing_gen_if if_main  ();
  vga_timing_gen_if if_p0    ();
  vga_timing_gen_if if_small ();

  vga_timing_gen dut_main (
    .vga_clk (vga_clk),
    .reset_n (rst_main_n),
    .vga     (if_main)
  );

  vga_timing_gen #(.PIPE_DELAY(0)) dut_p0 (
    .vga_clk (vga_clk),
    .reset_n (rst_main_n),
    .vga     (if_p0)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .PIPE_DELAY(1)
  ) dut_small (
    .vga_clk (vga_clk),
    .reset_n (rst_small_n),
    .vga     (if_small)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Reference raster as a function of edges counted since reset release.
  function automatic obs_t model(input int k, input int hv, input int hf,
                                 input int hsw, input int hb, input int vv,
                                 input int vf, input int vsw, input int vb);
    obs_t o;
    int ht, vt, idx, x, y;
    o = '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, ls: 1'b0};
    if (k <= 0) return o;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    idx = k % (ht * vt);
    x   = idx % ht;
    y   = idx / ht;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.blank = (x < hv) && (y < vv);
    o.hs    = !((x >= hv + hf) && (x < hv + hf + hsw));
    o.vs    = !((y >= vv + vf) && (y < vv + vf + vsw));
    o.fs    = (idx == 0);
    o.ls    = (x == 0);
    return o;
  endfunction

  function automatic obs_t model_main(input int k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic obs_t model_small(input int k);
    return model(k, 8, 2, 2, 2, 4, 1, 1, 1);
  endfunction

  function automatic vec_t mk(input int k, input int x, input int y,
                              input logic b, input logic h, input logic v,
                              input logic l, input logic f,
                              input logic bd, input logic hd);
    vec_t r;
    r.k = k; r.x = x; r.y = y; r.blank = b; r.hs = h; r.vs = v;
    r.ls = l; r.fs = f; r.blank_d = bd; r.hs_d = hd;
    return r;
  endfunction

  function automatic obs_t grab_main();
    return '{x: if_main.DrawX, y: if_main.DrawY, blank: if_main.blank,
             hs: if_main.hs, vs: if_main.vs, fs: if_main.frame_start,
             ls: if_main.line_start};
  endfunction

  function automatic obs_t grab_p0();
    return '{x: if_p0.DrawX, y: if_p0.DrawY, blank: if_p0.blank,
             hs: if_p0.hs, vs: if_p0.vs, fs: if_p0.frame_start,
             ls: if_p0.line_start};
  endfunction

  function automatic obs_t grab_small();
    return '{x: if_small.DrawX, y: if_small.DrawY, blank: if_small.blank,
             hs: if_small.hs, vs: if_small.vs, fs: if_small.frame_start,
             ls: if_small.line_start};
  endfunction

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic main_n, input logic small_n);
    rst_main_n  = main_n;
    rst_small_n = small_n;
  endtask

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s k=%0d actual=%h expected=%h", name, k, act, exp);
    end
  endtask

  vec_t vecs [20];
  obs_t e, ed;
  int   vi;
  int   hs_low_cnt, first_hs_x, blank_cnt, last_blank_x;
  int   fs_small_cnt, ls_small_cnt, vs_fall_cnt, fs_main_cnt, ls_main_cnt;
  logic prev_vs_small;

  initial begin
    tests_run = 0;
    failures  = 0;

    //             k     x    y  bl hs vs ls fs bd hd
    vecs[0]  = mk(1,    1,   0, 1, 1, 1, 0, 0, 0, 1);
    vecs[1]  = mk(2,    2,   0, 1, 1, 1, 0, 0, 0, 1);
    vecs[2]  = mk(3,    3,   0, 1, 1, 1, 0, 0, 1, 1);
    vecs[3]  = mk(639,  639, 0, 1, 1, 1, 0, 0, 1, 1);
    vecs[4]  = mk(640,  640, 0, 0, 1, 1, 0, 0, 1, 1);
    vecs[5]  = mk(642,  642, 0, 0, 1, 1, 0, 0, 0, 1);
    vecs[6]  = mk(655,  655, 0, 0, 1, 1, 0, 0, 0, 1);
    vecs[7]  = mk(656,  656, 0, 0, 0, 1, 0, 0, 0, 1);
    vecs[8]  = mk(657,  657, 0, 0, 0, 1, 0, 0, 0, 1);
    vecs[9]  = mk(658,  658, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[10] = mk(751,  751, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[11] = mk(752,  752, 0, 0, 1, 1, 0, 0, 0, 0);
    vecs[12] = mk(753,  753, 0, 0, 1, 1, 0, 0, 0, 0);
    vecs[13] = mk(754,  754, 0, 0, 1, 1, 0, 0, 0, 1);
    vecs[14] = mk(799,  799, 0, 0, 1, 1, 0, 0, 0, 1);
    vecs[15] = mk(800,  0,   1, 1, 1, 1, 1, 0, 0, 1);
    vecs[16] = mk(801,  1,   1, 1, 1, 1, 0, 0, 0, 1);
    vecs[17] = mk(802,  2,   1, 1, 1, 1, 0, 0, 1, 1);
    vecs[18] = mk(1456, 656, 1, 0, 0, 1, 0, 0, 0, 1);
    vecs[19] = mk(1600, 0,   2, 1, 1, 1, 1, 0, 0, 1);

    applyStimulus(1'b0, 1'b0);
    repeat (3) step();

    checkOutput("reset_main", 0, {7'd0, grab_main()},
                {7'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    checkOutput("reset_main_d", 0,
                {29'd0, if_main.hs_d, if_main.vs_d, if_main.blank_d}, 32'b110);
    checkOutput("reset_p0_d", 0,
                {29'd0, if_p0.hs_d, if_p0.vs_d, if_p0.blank_d}, 32'b110);
    checkOutput("reset_small", 0, {7'd0, grab_small()},
                {7'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});

    applyStimulus(1'b1, 1'b1);
    vi = 0;
    hs_low_cnt = 0; first_hs_x = -1; blank_cnt = 0; last_blank_x = -1;
    fs_small_cnt = 0; ls_small_cnt = 0; vs_fall_cnt = 0;
    fs_main_cnt = 0; ls_main_cnt = 0;
    prev_vs_small = 1'b1;

    for (int k = 1; k <= 1700; k++) begin
      step();

      if (vi < 20 && vecs[vi].k == k) begin
        checkOutput("vec_main", k, {7'd0, grab_main()},
                    {7'd0, 10'(vecs[vi].x), 10'(vecs[vi].y), vecs[vi].blank,
                     vecs[vi].hs, vecs[vi].vs, vecs[vi].fs, vecs[vi].ls});
        checkOutput("vec_main_d", k, {30'd0, if_main.blank_d, if_main.hs_d},
                    {30'd0, vecs[vi].blank_d, vecs[vi].hs_d});
        vi++;
      end

      if (k >= 800 && k < 1600) begin
        if (!if_main.hs) begin
          hs_low_cnt++;
          if (first_hs_x < 0) first_hs_x = int'(if_main.DrawX);
        end
        if (if_main.blank) begin
          blank_cnt++;
          last_blank_x = int'(if_main.DrawX);
        end
      end
      if (if_main.frame_start) fs_main_cnt++;
      if (if_main.line_start)  ls_main_cnt++;

      e = model_main(k);
      checkOutput("p0", k, {7'd0, grab_p0()}, {7'd0, e});
      checkOutput("p0_d", k, {29'd0, if_p0.hs_d, if_p0.vs_d, if_p0.blank_d},
                  {29'd0, e.hs, e.vs, e.blank});

      e  = model_small(k);
      ed = model_small(k - 1);
      checkOutput("small", k, {7'd0, grab_small()}, {7'd0, e});
      checkOutput("small_d", k,
                  {29'd0, if_small.hs_d, if_small.vs_d, if_small.blank_d},
                  {29'd0, ed.hs, ed.vs, ed.blank});
      if (if_small.frame_start) fs_small_cnt++;
      if (if_small.line_start)  ls_small_cnt++;
      if (prev_vs_small && !if_small.vs) begin
        vs_fall_cnt++;
        checkOutput("vs_fall_x", k, {22'd0, if_small.DrawX}, 32'd0);
      end
      prev_vs_small = if_small.vs;
    end

    checkOutput("hs_low_count",  1600, 32'(hs_low_cnt),   32'd96);
    checkOutput("hs_first_x",    1600, 32'(first_hs_x),   32'd656);
    checkOutput("blank_count",   1600, 32'(blank_cnt),    32'd640);
    checkOutput("blank_last_x",  1600, 32'(last_blank_x), 32'd639);
    checkOutput("fs_main_count", 1700, 32'(fs_main_cnt),  32'd0);
    checkOutput("ls_main_count", 1700, 32'(ls_main_cnt),  32'd2);
    checkOutput("fs_small_cnt",  1700, 32'(fs_small_cnt), 32'd17);
    checkOutput("ls_small_cnt",  1700, 32'(ls_small_cnt), 32'd121);
    checkOutput("vs_fall_count", 1700, 32'(vs_fall_cnt),  32'd17);

    // Park the small raster at (11,5), inside both sync pulses, then reset it.
    repeat (47) step();
    checkOutput("small_pre_reset", 1747, {7'd0, grab_small()},
                {7'd0, 10'd11, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    applyStimulus(1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      step();
      checkOutput("small_in_reset", r, {7'd0, grab_small()},
                  {7'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      checkOutput("small_in_reset_d", r,
                  {29'd0, if_small.hs_d, if_small.vs_d, if_small.blank_d},
                  32'b110);
    end

    applyStimulus(1'b1, 1'b1);
    step();
    checkOutput("small_restart", 1, {7'd0, grab_small()},
                {7'd0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    checkOutput("small_restart_d", 1,
                {29'd0, if_small.hs_d, if_small.vs_d, if_small.blank_d},
                32'b110);
    step();
    checkOutput("small_restart2", 2, {7'd0, grab_small()},
                {7'd0, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    checkOutput("small_restart2_d", 2,
                {29'd0, if_small.hs_d, if_small.vs_d, if_small.blank_d},
                32'b111);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 The block SHALL have parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 The block SHALL have parameter PIPE_DELAY, default 2, legal range 0..4: delay in clocks applied to the *_d outputs.
REQ-010 The block SHALL have port vga_clk, input, 1 bit: pixel clock, 25 MHz nominal.
REQ-011 The block SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-012 The block SHALL have port DrawX, output, 10 bits: current horizontal count.
REQ-013 The block SHALL have port DrawY, output, 10 bits: current vertical count.
REQ-014 The block SHALL have port blank, output, 1 bit: active-high display enable, 1 = visible pixel.
REQ-015 The block SHALL have port hs, output, 1 bit: hsync, active-low.
REQ-016 The block SHALL have port vs, output, 1 bit: vsync, active-low.
REQ-017 The block SHALL have port frame_start, output, 1 bit: one-clock pulse at count (0,0).
REQ-018 The block SHALL have port line_start, output, 1 bit: one-clock pulse whenever DrawX == 0.
REQ-019 The block SHALL have ports hs_d, vs_d and blank_d, output, 1 bit each: hs, vs and blank delayed by PIPE_DELAY clocks, for alignment with the two-clock sprite ROM/palette pipeline.

Function
REQ-020 H_TOTAL and V_TOTAL SHALL be the sums of their four parameters (800 and 525 at defaults); all counters SHALL be 10 bits wide.
REQ-021 DrawX SHALL increment every clock and wrap from H_TOTAL-1 to 0.
REQ-022 DrawY SHALL increment only on the clock where DrawX wraps, and SHALL wrap from V_TOTAL-1 to 0 when both counters wrap together.
REQ-023 blank SHALL be 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-024 hs SHALL be 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC.
REQ-025 vs SHALL be 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC; vs transitions SHALL coincide with DrawX == 0.
REQ-026 blank, hs, vs, frame_start and line_start SHALL be registered and computed from the next counter values, so each aligns with DrawX/DrawY in the same cycle with zero relative latency.
REQ-027 Each *_d output SHALL equal its source sampled PIPE_DELAY clocks earlier; PIPE_DELAY = 0 SHALL be a wire pass-through.
REQ-028 frame_start and line_start SHALL each be high for exactly one clock per event and never high during reset.

Reset
REQ-029 While reset_n == 0 at a vga_clk edge, outputs SHALL be: DrawX = 0, DrawY = 0, blank = 0, hs = 1, vs = 1, frame_start = 0, line_start = 0; every delay stage SHALL load hs_d = 1, vs_d = 1, blank_d = 0.
REQ-030 On the first edge after release, counters SHALL advance to (1,0) with blank = 1; pixel (0,0) of the first post-reset frame stays blanked, and the first frame_start occurs at the next wrap.
REQ-031 Assertion of reset_n mid-frame SHALL take effect on the next edge regardless of counter state, with no partial sync pulse extended.

Structure
REQ-032 The default timing constants, H_TOTAL/V_TOTAL derivation and a 10-bit coord_t typedef SHALL live in shared package vga_timing_pkg, which sprite modules also import.
REQ-033 The delay line SHALL be a single sub-module vga_sync_delay, parameterised by width and depth and instantiated once for {hs, vs, blank}.

Verification
REQ-034 Release reset, run 800*525 clocks -> DrawX/DrawY sequence (1,0)…(799,524),(0,0); frame_start exactly once, on (0,0).
REQ-035 Over one line -> hs low exactly at DrawX 656..751 (96 clocks); blank high exactly at DrawX 0..639 on lines 0..479.
REQ-036 Over one frame -> vs low exactly on DrawY 490..491, first asserting with DrawX == 0; 525 line_start pulses.
REQ-037 PIPE_DELAY = 2 -> blank_d rises 2 clocks after blank at DrawX 0; hs_d falls at DrawX 658. PIPE_DELAY = 0 -> *_d equal sources every cycle.
REQ-038 Assert reset_n = 0 at (700,300) for 3 clocks -> next edge gives DrawX = 0, DrawY = 0, hs = 1, blank = 0; after release, counting restarts at (1,0).
REQ-039 Reduced parameters (H 8/2/2/2, V 4/1/1/1) -> period 14 x 7 = 98 clocks, with every sync and blank edge at the computed counts.
